// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and round-robin helper for the traffic controller
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } state_t;

  localparam int MAX_APPR = 32;

  // First approach after cur (wrapping modulo n) with demand; 0 when none is found.
  function automatic int unsigned next_rr(input logic [MAX_APPR-1:0] dem,
                                          input int unsigned cur,
                                          input int unsigned n);
    int unsigned res;
    int unsigned idx;
    logic found;
    res   = 0;
    found = 1'b0;
    for (int unsigned k = 1; k < MAX_APPR; k++) begin
      idx = (cur + k) % n;
      if (k < n && !found && dem[idx[4:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick prescaler plus saturating per-phase tick counter
module phase_timer #(
  parameter int TICK_DIV = 1,
  parameter int TW       = 8
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          clr,
  output logic          tick,
  output logic [TW-1:0] t
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // The prescaler runs freely; only the phase count restarts on a state change.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      t <= '0;
    end else if (clr) begin
      t <= '0;
    end else if (tick && t != '1) begin
      t <= t + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// rtl/traffic_ctrl_multi.sv - N-approach traffic-light controller with round-robin demand service
module traffic_ctrl_multi #(
  parameter  int NUM_APPR  = 4,
  parameter  int TICK_DIV  = 1,
  parameter  int GREEN_MIN = 4,
  parameter  int GREEN_MAX = 8,
  parameter  int YELLOW_T  = 2,
  parameter  int ALLRED_T  = 1,
  parameter  int TW        = 8,
  localparam int IW        = $clog2(NUM_APPR)
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic [NUM_APPR-1:0] req,
  input  logic                flash,
  output logic [NUM_APPR-1:0] red,
  output logic [NUM_APPR-1:0] yel,
  output logic [NUM_APPR-1:0] grn,
  output logic [IW-1:0]       cur
);

  import traffic_pkg::*;

  state_t              state;
  state_t              state_nx;
  logic                tick;
  logic                clr;
  logic [TW-1:0]       t;
  logic [NUM_APPR-1:1] dem_q;
  logic [NUM_APPR-1:0] dem;
  logic [NUM_APPR-1:0] cur_oh;
  logic [IW-1:0]       nxt;
  logic                blink;
  logic                other_dem, side_dem, at_min, at_max, own_req, cur_main;
  logic                go_b, go_c, enter_green;

  phase_timer #(.TICK_DIV(TICK_DIV), .TW(TW)) u_timer (
    .Clk   (Clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick),
    .t     (t)
  );

  // The main road always counts as demanding, so it is the round-robin fallback.
  assign dem       = {dem_q, 1'b1};
  assign cur_oh    = {{(NUM_APPR-1){1'b0}}, 1'b1} << cur;
  assign other_dem = |(dem & ~cur_oh);
  assign side_dem  = |(dem_q & ~cur_oh[NUM_APPR-1:1]);
  assign at_min    = (t >= TW'(GREEN_MIN - 1));
  assign at_max    = (t >= TW'(GREEN_MAX - 1));
  assign own_req   = req[cur];
  assign cur_main  = (cur == '0);
  assign go_b      = at_min && other_dem && (cur_main || !own_req || at_max);
  assign go_c      = !cur_main && at_min && !own_req && !side_dem;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= ALL_RED;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ALL_RED: if (tick && t == TW'(ALLRED_T - 1)) state_nx = flash ? FLASH : GREEN;
      GREEN:   if (tick && (flash || go_b || go_c)) state_nx = YELLOW;
      YELLOW:  if (tick && t == TW'(YELLOW_T - 1)) state_nx = ALL_RED;
      FLASH:   if (tick && !flash) state_nx = ALL_RED;
      default: state_nx = ALL_RED;
    endcase
  end

  assign clr         = (state_nx != state);
  assign enter_green = (state == ALL_RED) && (state_nx == GREEN);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      dem_q <= '0;
      nxt   <= '0;
      cur   <= '0;
      blink <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_APPR; i++) begin
        dem_q[i] <= req[i] | (dem_q[i] & !(enter_green && (nxt == IW'(i))));
      end
      if (enter_green) cur <= nxt;
      if (state == GREEN && state_nx == YELLOW) begin
        nxt <= IW'(next_rr(MAX_APPR'(dem), 32'(cur), NUM_APPR));
      end
      if (state == FLASH && state_nx == ALL_RED) begin
        nxt   <= '0;
        blink <= 1'b0;
      end else if (state == FLASH && tick) begin
        blink <= ~blink;
      end
    end
  end

  always_comb begin
    red = '1;
    yel = '0;
    grn = '0;
    case (state)
      GREEN: begin
        grn = cur_oh;
        red = ~cur_oh;
      end
      YELLOW: begin
        yel = cur_oh;
        red = ~cur_oh;
      end
      FLASH: begin
        red = {{(NUM_APPR-1){blink}}, 1'b0};
        yel = {{(NUM_APPR-1){1'b0}}, blink};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb/tb_traffic_ctrl_multi.sv - directed vector bench for traffic_ctrl_multi
module tb_traffic_ctrl_multi;

  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic         flash = 1'b0;
  logic [N-1:0] red, yel, grn;
  logic [1:0]   cur;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  traffic_ctrl_multi #(
    .NUM_APPR(4), .TICK_DIV(1), .GREEN_MIN(4), .GREEN_MAX(8),
    .YELLOW_T(2), .ALLRED_T(1), .TW(8)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .req   (req),
    .flash (flash),
    .red   (red),
    .yel   (yel),
    .grn   (grn),
    .cur   (cur)
  );

  typedef struct {
    string        name;
    logic [N-1:0] req;
    logic         flash;
    logic [N-1:0] red;
    logic [N-1:0] yel;
    logic [N-1:0] grn;
    logic [1:0]   cur;
  } vec_t;

  vec_t tbl[$];

  // kind: G green, Y yellow, R all red, D flash dark, L flash lit
  function automatic vec_t mk(string name, logic [3:0] r, logic f, byte kind, int idx);
    vec_t v;
    v.name  = name;
    v.req   = r;
    v.flash = f;
    v.cur   = 2'(idx);
    v.red   = 4'b1111;
    v.yel   = 4'b0000;
    v.grn   = 4'b0000;
    case (kind)
      "G": begin v.grn = 4'(1 << idx); v.red = ~v.grn; end
      "Y": begin v.yel = 4'(1 << idx); v.red = ~v.yel; end
      "D": v.red = 4'b0000;
      "L": begin v.yel = 4'b0001; v.red = 4'b1110; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic add(string name, logic [3:0] r, logic f, byte kind, int idx, int rep);
    for (int i = 0; i < rep; i++) tbl.push_back(mk(name, r, f, kind, idx));
  endtask

  task automatic check(string name, logic [3:0] r, logic [3:0] y, logic [3:0] g, logic [1:0] c);
    n_checks++;
    if (red !== r || yel !== y || grn !== g || cur !== c) begin
      n_fail++;
      $display("FAIL %s: got red=%b yel=%b grn=%b cur=%0d, expected red=%b yel=%b grn=%b cur=%0d",
               name, red, yel, grn, cur, r, y, g, c);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    add("t2_pulse",       4'b0100, 1'b0, "G", 0, 1);
    add("t2_yel",         4'b0000, 1'b0, "Y", 0, 2);
    add("t2_allred",      4'b0000, 1'b0, "R", 0, 1);
    add("t2_green",       4'b0000, 1'b0, "G", 2, 1);
    add("t3_pulse1",      4'b0110, 1'b0, "G", 2, 1);
    add("t3_hold",        4'b0100, 1'b0, "G", 2, 6);
    add("t3_max_yel",     4'b0100, 1'b0, "Y", 2, 1);
    add("t3_yel",         4'b0000, 1'b0, "Y", 2, 1);
    add("t3_allred",      4'b0000, 1'b0, "R", 2, 1);
    add("t3_main",        4'b0000, 1'b0, "G", 0, 4);
    add("t3_main_yel",    4'b0000, 1'b0, "Y", 0, 2);
    add("t3_allred1",     4'b0000, 1'b0, "R", 0, 1);
    add("t3_green1",      4'b0000, 1'b0, "G", 1, 4);
    add("t3_yel1",        4'b0000, 1'b0, "Y", 1, 2);
    add("t3_allred2",     4'b0000, 1'b0, "R", 1, 1);
    add("t4_green2",      4'b0000, 1'b0, "G", 2, 4);
    add("t4_return_yel",  4'b0000, 1'b0, "Y", 2, 2);
    add("t4_allred",      4'b0000, 1'b0, "R", 2, 1);
    add("t4_rest",        4'b0000, 1'b0, "G", 0, 5);
    add("f_enter_yel",    4'b0000, 1'b1, "Y", 0, 2);
    add("f_allred",       4'b0000, 1'b1, "R", 0, 1);
    add("f_dark",         4'b0000, 1'b1, "D", 0, 1);
    add("f_lit",          4'b0000, 1'b1, "L", 0, 1);
    add("f_dark2",        4'b0000, 1'b1, "D", 0, 1);
    add("f_lit2",         4'b0000, 1'b1, "L", 0, 1);
    add("f_exit_allred",  4'b0000, 1'b0, "R", 0, 1);
    add("f_exit_green",   4'b0000, 1'b0, "G", 0, 1);
    add("f_min_ignored",  4'b0000, 1'b1, "Y", 0, 1);
    add("f_abort_yel",    4'b0000, 1'b0, "Y", 0, 1);
    add("f_abort_allred", 4'b0000, 1'b0, "R", 0, 1);
    add("f_abort_green",  4'b0000, 1'b0, "G", 0, 1);

    repeat (3) @(negedge Clk);
    check("reset_hold", 4'b1111, 4'b0000, 4'b0000, 2'd0);
    reset = 1'b1;
    #1;
    check("reset_release", 4'b1111, 4'b0000, 4'b0000, 2'd0);
    @(negedge Clk);
    check("first_green", 4'b1110, 4'b0000, 4'b0001, 2'd0);
    for (int i = 0; i < 49; i++) begin
      @(negedge Clk);
      check("rest_green", 4'b1110, 4'b0000, 4'b0001, 2'd0);
    end

    foreach (tbl[i]) begin
      req   = tbl[i].req;
      flash = tbl[i].flash;
      @(negedge Clk);
      check(tbl[i].name, tbl[i].red, tbl[i].yel, tbl[i].grn, tbl[i].cur);
    end

    // Main road at t=0 with a side demand: yellow appears after exactly GREEN_MIN ticks.
    req = 4'b1000;
    @(negedge Clk);
    req = 4'b0000;
    k = 0;
    while (yel == 4'b0000 && k < 10) begin
      @(negedge Clk);
      k++;
    end
    n_checks++;
    if (k != 3 || yel !== 4'b0001) begin
      n_fail++;
      $display("FAIL min_green_exit: got %0d extra cycles yel=%b, expected 3 yel=0001", k, yel);
    end

    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_yellow", 4'b1111, 4'b0000, 4'b0000, 2'd0);
    @(negedge Clk);
    check("reset_held", 4'b1111, 4'b0000, 4'b0000, 2'd0);
    reset = 1'b1;
    @(negedge Clk);
    check("post_reset_green", 4'b1110, 4'b0000, 4'b0001, 2'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("dem_cleared_rest", 4'b1110, 4'b0000, 4'b0001, 2'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
